mul_unit: RTL and testbench

- Shift-and-add unsigned multiplier datapath driven by the MUL1/MUL2_1/MUL2_2/MUL3/MUL4 one-hot state strobes of the controller's status counter.
- Returns is_all_zero to the controller to terminate the MUL2_2 loop.
- Drives the register-file write of the low product (MUL3) and updates the HI register (MUL4) before the controller returns to IF0.

---
 rtl/mul_unit.sv | 112 +++++++++++
 tb/tb_mul_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Shift-and-add unsigned multiplier datapath, sequenced by the controller's one-hot
// MUL1/MUL2_1/MUL2_2/MUL3/MUL4 strobes; yields the low product word and the HI register.
module mul_unit #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MUL1,
  input  logic             MUL2_1,
  input  logic             MUL2_2,
  input  logic             MUL3,
  input  logic             MUL4,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             is_all_zero,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi_reg,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_LOAD,
    OP_INIT,
    OP_STEP,
    OP_WRLO,
    OP_WRHI
  } op_e;

  op_e op;

  logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [2*WIDTH-1:0] acc_q,  acc_d;
  logic [CW-1:0]      cnt_q,  cnt_d;
  logic [WIDTH-1:0]   hi_q,   hi_d;
  logic               ovf_q,  ovf_d;

  // Overlapping strobes collapse to the highest-priority one.
  always_comb begin
    if (MUL1)        op = OP_LOAD;
    else if (MUL2_1) op = OP_INIT;
    else if (MUL2_2) op = OP_STEP;
    else if (MUL3)   op = OP_WRLO;
    else if (MUL4)   op = OP_WRHI;
    else             op = OP_NONE;
  end

  assign is_all_zero = (cnt_q == '0) | (EARLY_EXIT & (b_sh_q == '0));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    ovf_d  = ovf_q;
    unique case (op)
      OP_LOAD: begin
        a_sh_d = {{WIDTH{1'b0}}, src_a};
        b_sh_d = src_b;
      end
      OP_INIT: begin
        acc_d = '0;
        cnt_d = CNT_INIT;
      end
      OP_STEP: begin
        if (!is_all_zero) begin
          acc_d  = acc_q + (b_sh_q[0] ? a_sh_q : '0);
          a_sh_d = a_sh_q << 1;
          b_sh_d = b_sh_q >> 1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      OP_WRLO: ovf_d = |acc_q[2*WIDTH-1:WIDTH];
      OP_WRHI: hi_d  = acc_q[2*WIDTH-1:WIDTH];
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      ovf_q  <= ovf_d;
    end
  end

  // Reset gates the write so a concurrently reset controller never leaves a partial write.
  assign wr_en   = (op == OP_WRLO) && !reset;
  assign wr_data = wr_en ? acc_q[WIDTH-1:0] : '0;
  assign hi_reg  = hi_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: an early-exit and a full-length instance share stimulus;
// expected products are queued at MUL1 and compared at MUL3/MUL4.
module tb_mul_unit;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  logic m1, m21, m22, m3, m4;
  logic [W-1:0] src_a, src_b;

  logic         iaz_ee, wr_en_ee, ovf_ee;
  logic [W-1:0] wr_data_ee, hi_ee;
  logic         iaz_full, wr_en_full, ovf_full;
  logic [W-1:0] wr_data_full, hi_full;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    int           n;
  } exp_t;

  exp_t sb[$];

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_M1   = 5'b10000;
  localparam logic [4:0] S_M21  = 5'b01000;
  localparam logic [4:0] S_M22  = 5'b00100;
  localparam logic [4:0] S_M3   = 5'b00010;
  localparam logic [4:0] S_M4   = 5'b00001;

  always #5 clk = ~clk;

  mul_unit #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .reset(reset),
    .MUL1(m1), .MUL2_1(m21), .MUL2_2(m22), .MUL3(m3), .MUL4(m4),
    .src_a(src_a), .src_b(src_b),
    .is_all_zero(iaz_ee), .wr_en(wr_en_ee), .wr_data(wr_data_ee),
    .hi_reg(hi_ee), .ovf(ovf_ee)
  );

  mul_unit #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .reset(reset),
    .MUL1(m1), .MUL2_1(m21), .MUL2_2(m22), .MUL3(m3), .MUL4(m4),
    .src_a(src_a), .src_b(src_b),
    .is_all_zero(iaz_full), .wr_en(wr_en_full), .wr_data(wr_data_full),
    .hi_reg(hi_full), .ovf(ovf_full)
  );

  // Apply strobes at the falling edge; outputs are read 1 ns later, well before the rising edge.
  task automatic cyc(input logic [4:0] s, input logic r);
    @(negedge clk);
    {m1, m21, m22, m3, m4} = s;
    reset = r;
    #1;
  endtask

  function automatic int exp_iters(input logic [W-1:0] b, input bit full);
    int n = 0;
    if (full) return W;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Runs MUL2_2 until the selected instance raises is_all_zero; returns the iteration count.
  task automatic run_loop(input bit full, input string name, output int n);
    logic iaz;
    n = 0;
    forever begin
      cyc(S_M22, 1'b0);
      iaz = full ? iaz_full : iaz_ee;
      if (iaz) break;
      n++;
      if (n > 40) begin
        total++; bad++;
        $display("FAIL %s loop_timeout: is_all_zero still 0 after %0d iterations", name, n);
        break;
      end
    end
  endtask

  task automatic finish_op(input bit full, input string name, input int n);
    exp_t e;
    logic we;
    logic [W-1:0] wd;
    e = sb.pop_front();
    total++;
    if (n !== e.n) begin
      bad++; $display("FAIL %s iterations: got %0d expected %0d", name, n, e.n);
    end
    cyc(S_M3, 1'b0);
    we = full ? wr_en_full : wr_en_ee;
    wd = full ? wr_data_full : wr_data_ee;
    total++;
    if (we !== 1'b1) begin
      bad++; $display("FAIL %s mul3_wr_en: got %b expected 1", name, we);
    end
    total++;
    if (wd !== e.lo) begin
      bad++; $display("FAIL %s wr_data: got %h expected %h", name, wd, e.lo);
    end
    cyc(S_M4, 1'b0);
    total++;
    if ((full ? ovf_full : ovf_ee) !== e.ovf) begin
      bad++; $display("FAIL %s ovf: got %b expected %b", name, full ? ovf_full : ovf_ee, e.ovf);
    end
    total++;
    if ((full ? wr_en_full : wr_en_ee) !== 1'b0) begin
      bad++; $display("FAIL %s mul4_wr_en: got 1 expected 0", name);
    end
    cyc(S_NONE, 1'b0);
    total++;
    if ((full ? hi_full : hi_ee) !== e.hi) begin
      bad++; $display("FAIL %s hi_reg: got %h expected %h", name, full ? hi_full : hi_ee, e.hi);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input bit full);
    logic [2*W-1:0] p;
    exp_t e;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    e.lo  = p[W-1:0];
    e.hi  = p[2*W-1:W];
    e.ovf = |p[2*W-1:W];
    e.n   = exp_iters(b, full);
    sb.push_back(e);
  endtask

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit full,
                        input string name);
    int n;
    push_exp(a, b, full);
    src_a = a;
    src_b = b;
    cyc(S_M1, 1'b0);
    cyc(S_M21, 1'b0);
    run_loop(full, name, n);
    finish_op(full, name, n);
  endtask

  task automatic test_reset;
    cyc(S_NONE, 1'b1);
    cyc(S_NONE, 1'b0);
    total++;
    if (iaz_ee !== 1'b1 || iaz_full !== 1'b1) begin
      bad++; $display("FAIL reset_iaz: got ee=%b full=%b expected 1", iaz_ee, iaz_full);
    end
    total++;
    if (wr_en_ee !== 1'b0 || wr_data_ee !== '0) begin
      bad++; $display("FAIL reset_wr: got en=%b data=%h expected 0/0000", wr_en_ee, wr_data_ee);
    end
    total++;
    if (hi_ee !== '0 || ovf_ee !== 1'b0 || hi_full !== '0 || ovf_full !== 1'b0) begin
      bad++; $display("FAIL reset_hi_ovf: got hi=%h ovf=%b expected 0000/0", hi_ee, ovf_ee);
    end
  endtask

  task automatic test_basic;
    do_mul(16'd3, 16'd5, 1'b0, "mul_3x5");
    do_mul(16'hFFFF, 16'hFFFF, 1'b0, "mul_ffff");
  endtask

  task automatic test_early_exit;
    do_mul(16'd7, 16'd1, 1'b1, "full_7x1");
    do_mul(16'd7, 16'd1, 1'b0, "ee_7x1");
    do_mul(16'h1234, 16'd0, 1'b0, "zero_b");
  endtask

  task automatic test_mid_reset;
    do_mul(16'hFFFF, 16'hFFFF, 1'b0, "pre_reset");
    src_a = 16'h1234;
    src_b = 16'h00FF;
    cyc(S_M1, 1'b0);
    cyc(S_M21, 1'b0);
    for (int i = 0; i < 4; i++) cyc(S_M22, 1'b0);
    cyc(S_M22, 1'b1);
    total++;
    if (wr_en_ee !== 1'b0) begin
      bad++; $display("FAIL reset_cycle_wr_en: got %b expected 0", wr_en_ee);
    end
    cyc(S_NONE, 1'b0);
    total++;
    if (iaz_ee !== 1'b1 || iaz_full !== 1'b1) begin
      bad++; $display("FAIL midreset_iaz: got ee=%b full=%b expected 1", iaz_ee, iaz_full);
    end
    total++;
    if (hi_ee !== '0 || ovf_ee !== 1'b0) begin
      bad++; $display("FAIL midreset_hi_ovf: got hi=%h ovf=%b expected 0000/0", hi_ee, ovf_ee);
    end
    cyc(S_M3, 1'b0);
    total++;
    if (wr_data_ee !== '0 || wr_en_ee !== 1'b1) begin
      bad++; $display("FAIL midreset_acc: got en=%b data=%h expected 1/0000", wr_en_ee, wr_data_ee);
    end
    cyc(S_M3, 1'b1);
    total++;
    if (wr_en_ee !== 1'b0) begin
      bad++; $display("FAIL reset_mul3_wr_en: got %b expected 0", wr_en_ee);
    end
    do_mul(16'd2, 16'd3, 1'b0, "post_reset_2x3");
  endtask

  task automatic test_priority;
    int n;
    push_exp(16'h0009, 16'hFFFF, 1'b0);
    sb[0].n = 3;
    src_a = 16'h0009;
    src_b = 16'hFFFF;
    cyc(S_M1, 1'b0);
    cyc(S_M21, 1'b0);
    for (int i = 0; i < 12; i++) cyc(S_M22, 1'b0);
    cyc(S_M22 | S_M3, 1'b0);
    total++;
    if (wr_en_ee !== 1'b0 || wr_data_ee !== '0) begin
      bad++; $display("FAIL prio_wr_en: got en=%b data=%h expected 0/0000", wr_en_ee, wr_data_ee);
    end
    src_a = 16'hAAAA;
    src_b = 16'h5555;
    for (int i = 0; i < 10; i++) cyc(S_NONE, 1'b0);
    run_loop(1'b0, "prio_idle", n);
    finish_op(1'b0, "prio_idle", n);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      do_mul(a, b, 1'b0, $sformatf("b2b_%0d", i));
    end
  endtask

  initial begin
    reset = 1'b1;
    {m1, m21, m22, m3, m4} = S_NONE;
    src_a = '0;
    src_b = '0;
    test_reset();
    test_basic();
    test_early_exit();
    test_mid_reset();
    test_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
